// File: rtl/ram_write_post_pkg.sv
// Shared AXI constants, FSM encoding and entry layout for the posted byte-write path.
package ram_write_post_pkg;

    localparam int ENTRY_W = 29;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'h00;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFMD = 4'b0011;
    localparam logic [2:0] AXI_PROT_DATA   = 3'b000;
    localparam logic [1:0] BRESP_OKAY      = 2'b00;
    localparam logic [1:0] BRESP_SLVERR    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

    function automatic logic [7:0] byte_strobe(input logic [2:0] lane);
        return 8'b0000_0001 << lane;
    endfunction

endpackage

// File: rtl/ram_write_fifo.sv
// Synchronous posting FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module ram_write_fifo
    import ram_write_post_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ram_write_post.sv
// Posted byte writes from the ZX core to DDR: one single-beat AXI4 write per queued byte,
// with a snoop pulse on completion so ram_read can patch its cached line.
module ram_write_post
    import ram_write_post_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_memory,
    input  logic        areset,
    input  logic [20:0] addr,
    input  logic [7:0]  data,
    input  logic        wr,
    output logic        ready,
    output logic        idle,
    output logic        werr,
    output logic [20:0] write_addr,
    output logic [7:0]  write_data,
    output logic        write_signal,
    output logic [26:0] AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [7:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic [3:0]  AWCACHE,
    output logic [2:0]  AWPROT,
    output logic        AWLOCK,
    output logic [3:0]  AWQOS,
    output logic [3:0]  AWREGION,
    output logic [63:0] WDATA,
    output logic [7:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output state_t      fsm_state
);

    state_t        state_q;
    state_t        state_d;
    logic          load;
    logic          send_done;
    logic          commit;
    logic          fifo_full;
    logic          fifo_empty;
    logic [28:0]   fifo_dout;
    wr_entry_t     head;
    wr_entry_t     req;

    assign req   = '{addr: addr, data: data};
    assign head  = wr_entry_t'(fifo_dout);
    assign ready = !fifo_full;
    assign idle  = fifo_empty && (state_q == ST_IDLE);

    assign AWLEN     = AXI_LEN_SINGLE;
    assign AWSIZE    = AXI_SIZE_8B;
    assign AWBURST   = AXI_BURST_INCR;
    assign AWCACHE   = AXI_CACHE_BUFMD;
    assign AWPROT    = AXI_PROT_DATA;
    assign AWLOCK    = 1'b0;
    assign AWQOS     = 4'h0;
    assign AWREGION  = 4'h0;
    assign WLAST     = 1'b1;
    assign fsm_state = state_q;

    // Head stays in the FIFO until its B response so idle cannot go high mid-write.
    ram_write_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk_memory),
        .areset(areset),
        .push  (wr),
        .pop   (commit),
        .din   (req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_memory or posedge areset) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        send_done = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Each channel is done once its VALID is low or handshakes this edge.
                if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                    send_done = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (BVALID && BREADY) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_memory or posedge areset) begin
        if (areset) begin
            AWADDR       <= '0;
            AWVALID      <= 1'b0;
            WDATA        <= '0;
            WSTRB        <= '0;
            WVALID       <= 1'b0;
            BREADY       <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_signal <= 1'b0;
            werr         <= 1'b0;
        end else begin
            if (load) begin
                AWADDR  <= {6'b0, head.addr[20:3], 3'b000};
                WDATA   <= {8{head.data}};
                WSTRB   <= byte_strobe(head.addr[2:0]);
                AWVALID <= 1'b1;
                WVALID  <= 1'b1;
            end else begin
                if (AWVALID && AWREADY) AWVALID <= 1'b0;
                if (WVALID && WREADY)   WVALID  <= 1'b0;
            end

            if (send_done)   BREADY <= 1'b1;
            else if (commit) BREADY <= 1'b0;

            write_signal <= commit;
            // Error responses still commit the snoop; there is no retry.
            if (commit) begin
                write_addr <= head.addr;
                write_data <= head.data;
                werr       <= werr | (BRESP != BRESP_OKAY);
            end
        end
    end

endmodule
